// File: rtl/wb_port_arbiter_pkg.sv
// Shared core definitions for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

  // Core-wide default widths.
  localparam int CORE_DATA_WIDTH     = 32;
  localparam int CORE_REG_ADDR_WIDTH = 5;

  // r0 is hardwired to zero; writes aimed at it are discarded.
  localparam int R0_ADDR = 0;

  // Which source owns the register-file write port in the current cycle.
  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_PIPE = 2'd1,
    GRANT_FIFO = 2'd2
  } grant_e;

endpackage

// File: rtl/wb_fifo.sv
// In-order result buffer for multi-cycle unit write-backs. Exposes every
// slot's address plus a per-slot occupancy flag so the hazard check can scan it.
module wb_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int DATA_WIDTH = CORE_DATA_WIDTH,
  parameter int ADDR_WIDTH = CORE_REG_ADDR_WIDTH,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic [ADDR_WIDTH-1:0]            push_addr,
  input  logic [DATA_WIDTH-1:0]            push_data,
  input  logic                             pop,
  output logic [ADDR_WIDTH-1:0]            head_addr,
  output logic [DATA_WIDTH-1:0]            head_data,
  output logic [CW-1:0]                    count,
  output logic [DEPTH-1:0][ADDR_WIDTH-1:0] entry_addr,
  output logic [DEPTH-1:0]                 entry_valid
);

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two; the caller
  // never pushes when full nor pops when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // A slot is live when its distance from the read pointer is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PW-1:0] offset;
    assign offset         = PW'(i) - rd_ptr;
    assign entry_addr[i]  = addr_mem[i];
    assign entry_valid[i] = ({1'b0, offset} < count);
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between pipeline write-back
// and a multi-cycle unit (MCU). MCU results wait in an in-order FIFO; the
// pipeline wins by default, and a starvation counter eventually freezes the
// pipeline (stall_out) so buffered results can drain.
//
// MCU handshake: a result transfers on a rising edge where mcu_valid and
// mcu_ready are both high. mcu_ready depends only on the stored FIFO count,
// never on mcu_valid or on a pop happening in the same cycle. The MCU must
// hold mcu_addr/mcu_data stable while mcu_valid is high and mcu_ready is low.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = CORE_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = CORE_REG_ADDR_WIDTH,
  parameter int FIFO_DEPTH     = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pipe_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] pipe_wr_addr,
  input  logic [DATA_WIDTH-1:0]     pipe_wr_data,
  input  logic                      mcu_valid,
  input  logic [REG_ADDR_WIDTH-1:0] mcu_addr,
  input  logic [DATA_WIDTH-1:0]     mcu_data,
  output logic                      mcu_ready,
  input  logic [REG_ADDR_WIDTH-1:0] pend_query_addr,
  output logic                      pend_hit,
  output logic                      stall_out,
  output logic                      rf_wr_en,
  output logic [REG_ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [DATA_WIDTH-1:0]     rf_wr_data
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [REG_ADDR_WIDTH-1:0] R0 = REG_ADDR_WIDTH'(R0_ADDR);

  logic [CW-1:0]                            fifo_count;
  logic                                     fifo_empty;
  logic [REG_ADDR_WIDTH-1:0]                head_addr;
  logic [DATA_WIDTH-1:0]                    head_data;
  logic [FIFO_DEPTH-1:0][REG_ADDR_WIDTH-1:0] entry_addr;
  logic [FIFO_DEPTH-1:0]                    entry_valid;

  logic   pipe_req;
  logic   push;
  logic   pop;
  grant_e grant;
  logic [SW-1:0] starve_cnt;

  assign fifo_empty = (fifo_count == '0);
  assign mcu_ready  = (fifo_count < CW'(FIFO_DEPTH));
  // r0 writes: the pipeline request vanishes, the MCU result is consumed
  // by the handshake but never stored.
  assign pipe_req   = pipe_wr_en && (pipe_wr_addr != R0);
  assign push       = mcu_valid && mcu_ready && (mcu_addr != R0);
  assign pop        = (grant == GRANT_FIFO);

  wb_fifo #(
    .DEPTH      (FIFO_DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_addr   (mcu_addr),
    .push_data   (mcu_data),
    .pop         (pop),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .count       (fifo_count),
    .entry_addr  (entry_addr),
    .entry_valid (entry_valid)
  );

  // Port ownership: while stalled only the FIFO may write; otherwise the
  // pipeline first, then the FIFO head.
  always_comb begin
    grant = GRANT_NONE;
    if (stall_out) begin
      if (!fifo_empty) grant = GRANT_FIFO;
    end else if (pipe_req) begin
      grant = GRANT_PIPE;
    end else if (!fifo_empty) begin
      grant = GRANT_FIFO;
    end
  end

  // Register the granted write so it reaches the register file next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
    end else begin
      case (grant)
        GRANT_PIPE: begin
          rf_wr_en   <= 1'b1;
          rf_wr_addr <= pipe_wr_addr;
          rf_wr_data <= pipe_wr_data;
        end
        GRANT_FIFO: begin
          rf_wr_en   <= 1'b1;
          rf_wr_addr <= head_addr;
          rf_wr_data <= head_data;
        end
        default: begin
          rf_wr_en   <= 1'b0;
          rf_wr_addr <= '0;
          rf_wr_data <= '0;
        end
      endcase
    end
  end

  // Count cycles the FIFO loses to the pipeline; freeze the pipeline once
  // the limit is reached and release it after the FIFO has drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      stall_out  <= 1'b0;
    end else begin
      if (fifo_empty || pop) begin
        starve_cnt <= '0;
      end else if ((grant == GRANT_PIPE) && (starve_cnt != SW'(STARVE_LIMIT))) begin
        starve_cnt <= starve_cnt + SW'(1);
      end

      if (fifo_empty) begin
        stall_out <= 1'b0;
      end else if (starve_cnt == SW'(STARVE_LIMIT)) begin
        stall_out <= 1'b1;
      end
    end
  end

  // Hazard lookup: does any buffered result target the queried register?
  always_comb begin
    pend_hit = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_valid[i] && (entry_addr[i] == pend_query_addr)) pend_hit = 1'b1;
    end
    if (pend_query_addr == R0) pend_hit = 1'b0;
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios followed by random traffic,
// all checked every cycle against a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          pipe_wr_en;
  logic [AW-1:0] pipe_wr_addr;
  logic [DW-1:0] pipe_wr_data;
  logic          mcu_valid;
  logic [AW-1:0] mcu_addr;
  logic [DW-1:0] mcu_data;
  logic          mcu_ready;
  logic [AW-1:0] pend_query_addr;
  logic          pend_hit;
  logic          stall_out;
  logic          rf_wr_en;
  logic [AW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_wr_data;

  wb_port_arbiter #(
    .DATA_WIDTH     (DW),
    .REG_ADDR_WIDTH (AW),
    .FIFO_DEPTH     (DEPTH),
    .STARVE_LIMIT   (LIMIT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pipe_wr_en      (pipe_wr_en),
    .pipe_wr_addr    (pipe_wr_addr),
    .pipe_wr_data    (pipe_wr_data),
    .mcu_valid       (mcu_valid),
    .mcu_addr        (mcu_addr),
    .mcu_data        (mcu_data),
    .mcu_ready       (mcu_ready),
    .pend_query_addr (pend_query_addr),
    .pend_hit        (pend_hit),
    .stall_out       (stall_out),
    .rf_wr_en        (rf_wr_en),
    .rf_wr_addr      (rf_wr_addr),
    .rf_wr_data      (rf_wr_data)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;

  // Buffered MCU results, oldest first, packed as {addr, data}.
  logic [AW+DW-1:0] exp_q[$];
  int               m_starve;
  bit               m_stall;
  logic             m_rf_en;
  logic [AW-1:0]    m_rf_a;
  logic [DW-1:0]    m_rf_d;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_starve = 0;
    m_stall  = 1'b0;
    m_rf_en  = 1'b0;
    m_rf_a   = '0;
    m_rf_d   = '0;
  endtask

  // Drive one cycle's inputs (called just after a falling edge), then check
  // every output against the model.
  task automatic set_in(input logic pe, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                        input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                        input logic [AW-1:0] qa, input logic r);
    logic exp_ready;
    logic exp_hit;
    rst             = r;
    pipe_wr_en      = pe;
    pipe_wr_addr    = pa;
    pipe_wr_data    = pd;
    mcu_valid       = mv;
    mcu_addr        = ma;
    mcu_data        = md;
    pend_query_addr = qa;
    #1;
    exp_ready = (exp_q.size() < DEPTH);
    exp_hit   = 1'b0;
    foreach (exp_q[i]) begin
      if (exp_q[i][AW+DW-1:DW] == qa && qa != '0) exp_hit = 1'b1;
    end
    chk("mcu_ready",  32'(mcu_ready),  32'(exp_ready));
    chk("pend_hit",   32'(pend_hit),   32'(exp_hit));
    chk("stall_out",  32'(stall_out),  32'(m_stall));
    chk("rf_wr_en",   32'(rf_wr_en),   32'(m_rf_en));
    chk("rf_wr_addr", 32'(rf_wr_addr), 32'(m_rf_a));
    chk("rf_wr_data", rf_wr_data,      m_rf_d);
  endtask

  // Advance the model by one clock using the inputs currently driven,
  // then wait for the next falling edge.
  task automatic tick();
    bit            ready;
    bit            preq;
    bit            do_push;
    bit            nonempty;
    int            g;
    int            starve_n;
    bit            stall_n;
    logic [AW+DW-1:0] head;
    ready    = (exp_q.size() < DEPTH);
    preq     = pipe_wr_en && (pipe_wr_addr != '0);
    do_push  = mcu_valid && ready && (mcu_addr != '0);
    nonempty = (exp_q.size() != 0);
    g        = 0;
    if (rst) begin
      model_clear();
    end else begin
      if (m_stall)       g = nonempty ? 2 : 0;
      else if (preq)     g = 1;
      else if (nonempty) g = 2;

      head = nonempty ? exp_q[0] : '0;
      if (g == 1) begin
        m_rf_en = 1'b1; m_rf_a = pipe_wr_addr; m_rf_d = pipe_wr_data;
      end else if (g == 2) begin
        m_rf_en = 1'b1; m_rf_a = head[AW+DW-1:DW]; m_rf_d = head[DW-1:0];
      end else begin
        m_rf_en = 1'b0; m_rf_a = '0; m_rf_d = '0;
      end

      starve_n = m_starve;
      if (!nonempty || g == 2)     starve_n = 0;
      else if (g == 1 && m_starve < LIMIT) starve_n = m_starve + 1;

      stall_n = m_stall;
      if (!nonempty)               stall_n = 1'b0;
      else if (m_starve == LIMIT)  stall_n = 1'b1;

      m_starve = starve_n;
      m_stall  = stall_n;
      if (g == 2) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({mcu_addr, mcu_data});
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [AW-1:0] qa);
    set_in(1'b0, '0, '0, 1'b0, '0, '0, qa, 1'b0);
    tick();
  endtask

  task automatic do_rst();
    set_in(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b1);
    tick();
  endtask

  // ---------------- stimulus ----------------
  logic          rp_en;
  logic [AW-1:0] rp_a;
  logic [DW-1:0] rp_d;
  logic          rm_v;
  logic [AW-1:0] rm_a;
  logic [DW-1:0] rm_d;
  logic          rr;
  bit            took;
  int            idx;

  initial begin
    rst = 1'b1; pipe_wr_en = 1'b0; pipe_wr_addr = '0; pipe_wr_data = '0;
    mcu_valid = 1'b0; mcu_addr = '0; mcu_data = '0; pend_query_addr = '0;
    @(negedge clk);
    @(negedge clk);
    model_clear();

    // Reset state, then a lone MCU result reaches the port two cycles later.
    set_in(1'b0, '0, '0, 1'b1, 5'd7, 32'hDEADBEEF, '0, 1'b0);
    chk("rst_ready", 32'(mcu_ready), 32'd1);
    chk("rst_rf_en", 32'(rf_wr_en), 32'd0);
    tick();
    idle('0);
    set_in(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
    chk("mcu_wr_en",   32'(rf_wr_en),   32'd1);
    chk("mcu_wr_addr", 32'(rf_wr_addr), 32'd7);
    chk("mcu_wr_data", rf_wr_data,      32'hDEADBEEF);
    tick();

    // Starvation: pipeline writes r3 every cycle while r9 waits.
    do_rst();
    for (int k = 0; k < 10; k++) begin
      set_in(1'b1, 5'd3, DW'(k + 100), (k == 0), 5'd9, 32'h0000_0909, '0, 1'b0);
      if (k == 5) chk("starve_no_stall_yet", 32'(stall_out), 32'd0);
      if (k == 6) chk("starve_stall_set",    32'(stall_out), 32'd1);
      if (k == 7) chk("starve_r9_written",   32'(rf_wr_addr), 32'd9);
      if (k == 8) chk("starve_stall_clear",  32'(stall_out), 32'd0);
      tick();
    end

    // FIFO fills behind a busy pipeline; the third result waits for a pop.
    do_rst();
    idx = 0;
    for (int k = 0; k < 16; k++) begin
      set_in(1'b1, 5'd3, DW'(k), (idx < 3), AW'(10 + idx), DW'(32'hA0 + idx), '0, 1'b0);
      if (k == 2) chk("full_not_ready", 32'(mcu_ready), 32'd0);
      took = (idx < 3) && (exp_q.size() < DEPTH);
      tick();
      if (took) idx++;
    end

    // Pipeline r0 request is ignored; MCU r0 result is consumed, never written.
    do_rst();
    set_in(1'b0, '0, '0, 1'b1, 5'd5, 32'h55, '0, 1'b0);
    tick();
    set_in(1'b1, 5'd0, 32'h111, 1'b0, '0, '0, '0, 1'b0);
    tick();
    set_in(1'b1, 5'd0, 32'h222, 1'b1, 5'd0, 32'hBAD, '0, 1'b0);
    chk("r0_fifo_granted", 32'(rf_wr_addr), 32'd5);
    chk("r0_mcu_ready",    32'(mcu_ready),  32'd1);
    tick();
    set_in(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
    chk("r0_no_write_a", 32'(rf_wr_en), 32'd0);
    tick();
    set_in(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
    chk("r0_no_write_b", 32'(rf_wr_en), 32'd0);
    tick();

    // Hazard query against a buffered r12, then reset clears it.
    do_rst();
    set_in(1'b1, 5'd3, 32'h1, 1'b1, 5'd12, 32'hC, '0, 1'b0);
    tick();
    set_in(1'b1, 5'd3, 32'h2, 1'b0, '0, '0, 5'd12, 1'b0);
    chk("query_12_hit", 32'(pend_hit), 32'd1);
    tick();
    set_in(1'b1, 5'd3, 32'h3, 1'b0, '0, '0, 5'd0, 1'b0);
    chk("query_0_miss", 32'(pend_hit), 32'd0);
    tick();
    set_in(1'b1, 5'd3, 32'h4, 1'b0, '0, '0, 5'd13, 1'b0);
    chk("query_13_miss", 32'(pend_hit), 32'd0);
    tick();
    set_in(1'b1, 5'd3, 32'h5, 1'b0, '0, '0, 5'd12, 1'b1);
    tick();
    set_in(1'b0, '0, '0, 1'b0, '0, '0, 5'd12, 1'b0);
    chk("post_rst_hit",   32'(pend_hit), 32'd0);
    chk("post_rst_rf_en", 32'(rf_wr_en), 32'd0);
    tick();

    // Random traffic: pipeline holds its request while stalled, MCU holds
    // its result until accepted, occasional mid-run resets.
    rp_en = 1'b0; rp_a = '0; rp_d = '0;
    rm_v = 1'b0; rm_a = '0; rm_d = '0;
    for (int k = 0; k < 600; k++) begin
      if (!m_stall) begin
        rp_en = 1'($urandom_range(0, 1));
        rp_a  = AW'($urandom_range(0, 15));
        rp_d  = $urandom;
      end
      if (!rm_v) begin
        rm_v = ($urandom_range(0, 2) != 0);
        rm_a = AW'($urandom_range(0, 15));
        rm_d = $urandom;
      end
      rr = ($urandom_range(0, 63) == 0);
      set_in(rp_en, rp_a, rp_d, rm_v, rm_a, rm_d, AW'($urandom_range(0, 15)), rr);
      took = rm_v && (exp_q.size() < DEPTH);
      tick();
      if (took || rr) rm_v = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  DATA_WIDTH, 32, register data width
  REG_ADDR_WIDTH, 5, register address width
  FIFO_DEPTH, 2, pending multi-cycle results (power of 2)
  STARVE_LIMIT, 4, consecutive lost cycles before stall
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock; all state on rising edge
  rst  in  1  synchronous, active-high reset
  pipe_wr_en  in  1  pipeline write-back request
  pipe_wr_addr  in  REG_ADDR_WIDTH  pipeline destination register
  pipe_wr_data  in  DATA_WIDTH  pipeline write data
  mcu_valid  in  1  multi-cycle unit result valid
  mcu_addr  in  REG_ADDR_WIDTH  multi-cycle unit destination
  mcu_data  in  DATA_WIDTH  multi-cycle unit result
  mcu_ready  out  1  result accepted this cycle when high with mcu_valid
  pend_query_addr  in  REG_ADDR_WIDTH  hazard query address
  pend_hit  out  1  query matches a buffered result
  stall_out  out  1  pipeline freeze request
  rf_wr_en  out  1  register file write enable
  rf_wr_addr  out  REG_ADDR_WIDTH  register file write address
  rf_wr_data  out  DATA_WIDTH  register file write data
REQ-003 One clock (clk); reset rst is synchronous and active-high.

Function
REQ-004 Shares the single register-file write port between pipeline write-back and the multi-cycle unit (MCU).
REQ-005 rf_wr_* SHALL be registered: a grant in cycle N appears on rf_wr_* in cycle N+1.
REQ-006 Writes to address 0 SHALL be dropped (r0 hardwired): pipeline request treated as absent; MCU result accepted but not buffered.
REQ-007 mcu_ready SHALL equal (FIFO count < FIFO_DEPTH), from current count only; no same-cycle pop bypass.
REQ-008 Accepted MCU results SHALL be pushed into an in-order FIFO; no direct MCU-to-port bypass.
REQ-009 Grant priority when stall_out=0: valid pipeline request (pipe_wr_en=1, addr!=0) first; else FIFO head popped; else rf_wr_en=0 next cycle.
REQ-010 When stall_out=1: pipe_wr_en SHALL be ignored and FIFO head granted; pipeline holds its write-back stage and re-presents it after release.
REQ-011 starve_cnt SHALL increment (saturating at STARVE_LIMIT) each cycle FIFO non-empty and pipeline granted; clear on any FIFO pop or when FIFO empty.
REQ-012 stall_out SHALL be registered: set in cycle after starve_cnt reaches STARVE_LIMIT; clear in cycle after FIFO becomes empty.
REQ-013 Simultaneous push and pop SHALL both occur; count unchanged.
REQ-014 pend_hit SHALL be combinational: 1 iff any valid FIFO entry has address == pend_query_addr and pend_query_addr != 0.
REQ-015 FIFO pointers SHALL wrap modulo FIFO_DEPTH; push when full and pop when empty are impossible by construction.

Reset
REQ-016 While rst=1 at a clock edge: FIFO emptied, starve_cnt=0, stall_out=0, rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0.
REQ-017 mcu_ready SHALL be 1 and pend_hit 0 in the first cycle after reset; reset mid-operation discards buffered results.

Structure
REQ-018 DATA_WIDTH, REG_ADDR_WIDTH defaults and the r0 address constant SHALL live in the shared core package.
REQ-019 FIFO SHALL be sub-module wb_fifo (sync, parameterised depth/width, exposes entry addresses for pend_hit).

Verification
REQ-020 Idle pipeline; MCU pushes addr 7 data 0xDEADBEEF -> rf_wr_en=1, addr 7, data 0xDEADBEEF two cycles after acceptance.
REQ-021 Pipeline writes addr 3 every cycle, MCU pushes addr 9 -> after 4 lost cycles stall_out=1, addr 9 written, stall_out=0 the cycle after FIFO empties.
REQ-022 Two MCU pushes with pipeline busy -> mcu_ready=0 with FIFO full; third result held until pop; pops in push order.
REQ-023 pipe_wr_addr=0 with pipe_wr_en=1 and FIFO holding addr 5 -> addr 5 granted; no write to r0; MCU addr 0 -> accepted, never written.
REQ-024 FIFO holds addr 12; query 12 -> pend_hit=1; query 0 or 13 -> 0; rst asserted -> pend_hit=0, rf_wr_en=0 next cycle.
